alu_rr_arbiter: RTL

ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

---
 rtl/alu_ctrl_pkg.sv | 40 ++++
 rtl/ALU_4bit.sv | 77 +++++++
 rtl/alu_rr_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encodings, requester ids,
// the latched-operand record and the grant-selection helper.
// Pure declarations; no logic, no latency, no flow control of its own.
package alu_ctrl_pkg;

    // FSM states of the arbiter; encodings are fixed so waveforms and logs stay readable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Requester identifiers; also the encoding used for rsp_id and the priority pointer.
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    // One accepted operation as latched from the winning requester.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
    } alu_opnd_t;

    // Picks the winner among the valid requesters. With both valid, round-robin
    // follows the pointer and fixed priority always favours requester 0. A lone
    // valid requester always wins regardless of the pointer.
    function automatic logic pick_grant(input logic v0, input logic v1,
                                        input logic ptr, input logic fair);
        logic id;
        if (v0 && v1) begin
            id = fair ? ptr : REQ_ID0;
        end else if (v1) begin
            id = REQ_ID1;
        end else begin
            id = REQ_ID0;
        end
        return id;
    endfunction

endpackage

// File: rtl/ALU_4bit.sv
// Purpose: 4-bit combinational ALU with two 4-bit result outputs (x = primary, y = secondary).
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
//
// Ports:
//   a, b  : 4-bit operands
//   op    : 4-bit opcode
//   x, y  : 4-bit results
//
// Opcodes:
//   0 ADD : x = a+b (low nibble),      y = carry out
//   1 SUB : x = a-b (mod 16),          y = borrow (a < b)
//   2 AND : x = a & b,                 y = 0
//   3 OR  : x = a | b,                 y = 0
//   4 XOR : x = a ^ b,                 y = 0
//   5 MUL : {y,x} = a * b (full 8-bit product)
//   6 SHL : x = a << b[1:0],           y = 0
//   7 SHR : x = a >> b[1:0],           y = 0
//   8 CMP : x = (a == b),              y = (a < b)
//   9 MAX : x = max(a,b),              y = min(a,b)
//   10-15 PASS : x = a,                y = b
module ALU_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] op,
    output logic [3:0] x,
    output logic [3:0] y
);

    logic [4:0] sum;
    logic [7:0] prod;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign prod = {4'b0000, a} * {4'b0000, b};

    always_comb begin
        x = 4'h0;
        y = 4'h0;
        case (op)
            4'd0: begin
                x = sum[3:0];
                y = {3'b000, sum[4]};
            end
            4'd1: begin
                x = a - b;
                y = {3'b000, (a < b)};
            end
            4'd2: x = a & b;
            4'd3: x = a | b;
            4'd4: x = a ^ b;
            4'd5: begin
                x = prod[3:0];
                y = prod[7:4];
            end
            4'd6: x = a << b[1:0];
            4'd7: x = a >> b[1:0];
            4'd8: begin
                x = {3'b000, (a == b)};
                y = {3'b000, (a < b)};
            end
            4'd9: begin
                if (a > b) begin
                    x = a;
                    y = b;
                end else begin
                    x = b;
                    y = a;
                end
            end
            default: begin
                x = a;
                y = b;
            end
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Purpose: shares one ALU_4bit between two valid/ready requesters, round-robin or fixed priority.
// Latency: accept in cycle N -> rsp_valid in N+2; one operation in flight, issue interval >= 3 cycles.
// Backpressure: rsp_ready low holds the response stable in RESP; no new grant until it is taken.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   reqN_valid / reqN_ready       : requester N handshake (ready only in IDLE, combinational)
//   reqN_a, reqN_b, reqN_op       : requester N operands and opcode (sampled at grant only)
//   rsp_valid / rsp_ready         : result handshake
//   rsp_id                        : requester owning the result
//   rsp_x, rsp_y                  : registered ALU results
//   op_count                      : completed-transaction counter, wraps at 256
module alu_rr_arbiter #(
    parameter int FAIR = 1
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [3:0] req0_op,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [3:0] req1_op,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_x,
    output logic [3:0] rsp_y,

    output logic [7:0] op_count
);

    import alu_ctrl_pkg::*;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;        // requester favoured on the next contended grant
    logic       id_q, id_d;          // owner of the in-flight operation
    alu_opnd_t  opnd_q, opnd_d;      // latched operands; the only source for the ALU
    logic [3:0] rsp_x_q, rsp_x_d;
    logic [3:0] rsp_y_q, rsp_y_d;
    logic [7:0] cnt_q, cnt_d;

    logic       grant;
    logic [3:0] alu_x;
    logic [3:0] alu_y;

    assign grant = pick_grant(req0_valid, req1_valid, ptr_q, FAIR != 0);

    // The ALU only ever sees the latched operands, so requester inputs moving
    // after the grant cannot disturb the result being computed.
    ALU_4bit u_alu (
        .a  (opnd_q.a),
        .b  (opnd_q.b),
        .op (opnd_q.op),
        .x  (alu_x),
        .y  (alu_y)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        opnd_d     = opnd_q;
        rsp_x_d    = rsp_x_q;
        rsp_y_d    = rsp_y_q;
        cnt_d      = cnt_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ready is suppressed under reset so no requester believes it was
                // accepted on a cycle whose state update is discarded.
                if (!rst && (req0_valid || req1_valid)) begin
                    if (grant == REQ_ID1) begin
                        req1_ready = 1'b1;
                        opnd_d     = '{a: req1_a, b: req1_b, op: req1_op};
                    end else begin
                        req0_ready = 1'b1;
                        opnd_d     = '{a: req0_a, b: req0_b, op: req0_op};
                    end
                    id_d    = grant;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                rsp_x_d = alu_x;
                rsp_y_d = alu_y;
                state_d = ST_RESP;
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    // Hand priority to whoever did not win this round.
                    ptr_d   = ~id_q;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= REQ_ID0;
            id_q    <= REQ_ID0;
            opnd_q  <= '0;
            rsp_x_q <= 4'h0;
            rsp_y_q <= 4'h0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            opnd_q  <= opnd_d;
            rsp_x_q <= rsp_x_d;
            rsp_y_q <= rsp_y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_y     = rsp_y_q;
    assign op_count  = cnt_q;

endmodule
